// File: rtl/window_pkg.sv
// Types and sizes shared between the 3x3 window generator and the downstream filter.
package window_pkg;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned WIN_SIZE = 9;

    typedef logic [DATA_W-1:0]     pixel_t;
    typedef pixel_t [WIN_SIZE-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// Two-line pixel store: simple dual-port RAM, synchronous read, one word per column.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-to-3x3 window generator: tracks pixel position, keeps two previous lines
// in a line buffer and emits one window per interior pixel with a start pulse.
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = window_pkg::DATA_W
) (
    input  logic                             iClk,
    input  logic                             iRst,
    input  logic [DATA_W-1:0]                iData,
    input  logic                             iValid,
    input  logic                             iSOF,
    output logic [WIN_SIZE-1:0][DATA_W-1:0]  oWindow,
    output logic                             oStart,
    output logic [10:0]                      oX,
    output logic [9:0]                       oY,
    output logic                             oOverrun
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
    localparam logic [9:0]  Y_LAST = 10'(IMG_HEIGHT - 1);

    logic [10:0] x;
    logic [9:0]  y;
    logic        acc_prev;
    logic        accept;
    logic [10:0] px;
    logic [9:0]  py;

    logic              s1_valid, s2_valid;
    logic [10:0]       s1_x, s2_x;
    logic [9:0]        s1_y, s2_y;
    logic [DATA_W-1:0] s1_data, s2_data;

    logic [2*DATA_W-1:0]              rd_data;
    logic [2*DATA_W-1:0]              wr_data;
    logic [WIN_SIZE-1:0][DATA_W-1:0]  win, win_next;
    logic                             emit;

    always_comb begin
        accept = iValid && !acc_prev;
        px     = iSOF ? '0 : x;
        py     = iSOF ? '0 : y;
    end

    // Word layout {line-2, line-1}: the old line-1 ages into line-2 on write.
    always_comb begin
        wr_data = {rd_data[DATA_W-1:0], s2_data};
    end

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (2 * DATA_W),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (iClk),
        .rd_en   (s1_valid),
        .rd_addr (s1_x[AW-1:0]),
        .rd_data (rd_data),
        .wr_en   (s2_valid),
        .wr_addr (s2_x[AW-1:0]),
        .wr_data (wr_data)
    );

    always_comb begin
        win_next    = win;
        win_next[0] = win[1];
        win_next[1] = win[2];
        win_next[2] = rd_data[2*DATA_W-1:DATA_W];
        win_next[3] = win[4];
        win_next[4] = win[5];
        win_next[5] = rd_data[DATA_W-1:0];
        win_next[6] = win[7];
        win_next[7] = win[8];
        win_next[8] = s2_data;
        emit        = s2_valid && (s2_x >= 11'd2) && (s2_y >= 10'd2);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            x        <= '0;
            y        <= '0;
            acc_prev <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_data  <= '0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_data  <= '0;
            win      <= '0;
            oWindow  <= '0;
            oStart   <= 1'b0;
            oX       <= '0;
            oY       <= '0;
            oOverrun <= 1'b0;
        end else begin
            acc_prev <= accept;
            s1_valid <= accept;
            if (accept) begin
                s1_x    <= px;
                s1_y    <= py;
                s1_data <= iData;
                if (px == X_LAST) begin
                    x <= '0;
                    y <= (py == Y_LAST) ? '0 : py + 10'd1;
                end else begin
                    x <= px + 11'd1;
                    y <= py;
                end
                if (iSOF) begin
                    oOverrun <= 1'b0;
                end
            end else if (iValid) begin
                oOverrun <= 1'b1;
            end

            s2_valid <= s1_valid;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_data  <= s1_data;

            oStart <= emit;
            if (s2_valid) begin
                win <= win_next;
            end
            // Border pixels still shift the window but never publish it.
            if (emit) begin
                oWindow <= win_next;
                oX      <= s2_x - 11'd1;
                oY      <= s2_y - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised and directed bench for window_3x3_gen against a frame-image model.
module tb_window_3x3_gen;
    import window_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 10;

    logic              iClk;
    logic              iRst;
    logic [DW-1:0]     iData;
    logic              iValid;
    logic              iSOF;
    window_t           oWindow;
    logic              oStart;
    logic [10:0]       oX;
    logic [9:0]        oY;
    logic              oOverrun;

    window_3x3_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iData    (iData),
        .iValid   (iValid),
        .iSOF     (iSOF),
        .oWindow  (oWindow),
        .oStart   (oStart),
        .oX       (oX),
        .oY       (oY),
        .oOverrun (oOverrun)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        int          edge_n;
        window_t     win;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] img [H][W];
    int            mx, my;
    int            last_acc;
    logic          m_overrun;
    window_t       last_win;
    logic [10:0]   last_x;
    logic [9:0]    last_y;
    int            edge_cnt;
    int            pulse_cnt;
    int            n_checks;
    int            n_err;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic check_outputs();
        logic exp_start;
        while (q.size() > 0 && q[0].edge_n < edge_cnt) void'(q.pop_front());
        check_eq("overrun", 128'(oOverrun), 128'(m_overrun));
        exp_start = (q.size() > 0) && (q[0].edge_n == edge_cnt);
        check_eq("start", 128'(oStart), 128'(exp_start));
        if (oStart) pulse_cnt++;
        if (exp_start) begin
            last_win = q[0].win;
            last_x   = q[0].x;
            last_y   = q[0].y;
            void'(q.pop_front());
        end
        check_eq("window", 128'(oWindow), 128'(last_win));
        check_eq("x", 128'(oX), 128'(last_x));
        check_eq("y", 128'(oY), 128'(last_y));
    endtask

    task automatic model_drive(input logic s, input logic [DW-1:0] d);
        int e;
        e = edge_cnt + 1;
        if (last_acc == e - 1) begin
            m_overrun = 1'b1;
        end else begin
            last_acc = e;
            if (s) begin
                mx = 0;
                my = 0;
                m_overrun = 1'b0;
            end
            img[my][mx] = d;
            if (mx >= 2 && my >= 2) begin
                exp_t t;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        t.win[r*3+c] = img[my-2+r][mx-2+c];
                t.edge_n = e + 2;
                t.x = 11'(mx - 1);
                t.y = 10'(my - 1);
                q.push_back(t);
            end
            mx = mx + 1;
            if (mx == W) begin
                mx = 0;
                my = (my + 1) % H;
            end
        end
    endtask

    task automatic tick(input logic v, input logic s, input logic [DW-1:0] d);
        @(negedge iClk);
        check_outputs();
        iValid = v;
        iSOF   = s;
        iData  = d;
        if (v && iRst) model_drive(s, d);
        @(posedge iClk);
        edge_cnt++;
    endtask

    task automatic send_pixel(input logic s, input logic [DW-1:0] d, input int gap);
        tick(1'b1, s, d);
        for (int i = 1; i < gap; i++) tick(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input int n, input int gap);
        for (int k = 0; k < n; k++)
            send_pixel(k == 0, DW'(16 * (k / W) + (k % W)), gap);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    task automatic apply_reset();
        @(negedge iClk);
        iValid = 1'b0;
        iSOF   = 1'b0;
        iData  = '0;
        #2 iRst = 1'b0;
        #1;
        check_eq("rst_start", 128'(oStart), 128'(0));
        check_eq("rst_overrun", 128'(oOverrun), 128'(0));
        check_eq("rst_x", 128'(oX), 128'(0));
        check_eq("rst_y", 128'(oY), 128'(0));
        check_eq("rst_window", 128'(oWindow), 128'(0));
        q.delete();
        mx = 0;
        my = 0;
        last_acc  = -10;
        m_overrun = 1'b0;
        last_win  = '0;
        last_x    = '0;
        last_y    = '0;
        @(posedge iClk);
        edge_cnt++;
        drain(2);
        #1 iRst = 1'b1;
    endtask

    initial begin
        window_t ref_last;
        iRst = 1'b1;
        iValid = 1'b0;
        iSOF = 1'b0;
        iData = '0;
        edge_cnt = 0;
        n_checks = 0;
        n_err = 0;
        pulse_cnt = 0;
        apply_reset();

        // First frame, spacing 2, pixel = 16*y+x
        pulse_cnt = 0;
        send_frame(16, 2);
        drain(4);
        check_eq("f1_pulses", 128'(pulse_cnt), 128'(4));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                ref_last[r*3+c] = DW'(16 * (1 + r) + (1 + c));
        check_eq("f1_last_win", 128'(oWindow), 128'(ref_last));
        check_eq("f1_last_x", 128'(oX), 128'(2));
        check_eq("f1_last_y", 128'(oY), 128'(2));

        // Back-to-back valid: second pixel dropped, flag sticky until SOF
        tick(1'b1, 1'b1, 10'd5);
        tick(1'b1, 1'b0, 10'd7);
        drain(4);
        check_eq("ovr_held", 128'(oOverrun), 128'(1));
        pulse_cnt = 0;
        send_frame(16, 2);
        drain(4);
        check_eq("ovr_cleared", 128'(oOverrun), 128'(0));
        check_eq("ovr_pulses", 128'(pulse_cnt), 128'(4));

        // Reset mid-frame after 7 pixels
        send_frame(7, 2);
        apply_reset();
        pulse_cnt = 0;
        send_frame(16, 2);
        drain(4);
        check_eq("rst_pulses", 128'(pulse_cnt), 128'(4));

        // SOF mid-frame after 5 pixels
        send_frame(5, 2);
        drain(4);
        pulse_cnt = 0;
        send_frame(16, 2);
        drain(4);
        check_eq("sof_pulses", 128'(pulse_cnt), 128'(4));

        // Wide spacing: outputs must hold between pulses
        pulse_cnt = 0;
        send_frame(16, 5);
        drain(6);
        check_eq("hold_pulses", 128'(pulse_cnt), 128'(4));

        // Random data, spacing and occasional SOF
        send_pixel(1'b1, DW'($urandom_range(0, 1023)), 2);
        for (int i = 0; i < 400; i++)
            send_pixel($urandom_range(0, 29) == 0, DW'($urandom_range(0, 1023)),
                       $urandom_range(1, 4));
        drain(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
